// File: rtl/matmul_pkg.sv
// Shared defaults and FSM state type for the matmul_driver block.
package matmul_pkg;

    localparam int unsigned N_DEF       = 3;
    localparam int unsigned DIN_DEF     = 3;
    localparam int unsigned DOUT_DEF    = 3;
    localparam int unsigned WIDTH_DEF   = 8;
    localparam int unsigned TIMEOUT_DEF = 1000;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        RUN,
        DRAIN
    } state_t;

endpackage

// File: rtl/matmul_idx_counter.sv
// Row-major row/column index counter with parameterised bounds; wraps to 0 after the last element.
module matmul_idx_counter #(
    parameter  int unsigned ROWS = 3,
    parameter  int unsigned COLS = 3,
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic row_end;
    logic col_end;

    assign row_end = (row == RW'(ROWS - 1));
    assign col_end = (col == CW'(COLS - 1));
    assign last    = row_end && col_end;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_driver.sv
// Streams A and B into registered operand arrays, handshakes with a multiplier, then drains C.
// Optional RUN watchdog enabled by defining MATMUL_DRIVER_TIMEOUT_EN.
module matmul_driver
    import matmul_pkg::*;
#(
    parameter  int unsigned N       = N_DEF,
    parameter  int unsigned DIN     = DIN_DEF,
    parameter  int unsigned DOUT    = DOUT_DEF,
    parameter  int unsigned WIDTHA  = WIDTH_DEF,
    parameter  int unsigned WIDTHB  = WIDTH_DEF,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEF,
    localparam int unsigned W       = (WIDTHA > WIDTHB) ? WIDTHA : WIDTHB,
    localparam int unsigned WO      = WIDTHA + WIDTHB
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  in_data,
    output logic                 START,
    input  logic                 DONE,
    output logic signed [WIDTHA-1:0] a [N][DIN],
    output logic signed [WIDTHB-1:0] b [DIN][DOUT],
    input  logic signed [WO-1:0] c [N][DOUT],
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [WO-1:0] out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned NW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (DIN > 1) ? $clog2(DIN) : 1;
    localparam int unsigned OW = (DOUT > 1) ? $clog2(DOUT) : 1;

    state_t state;
    logic signed [WO-1:0] res [N][DOUT];

    logic [NW-1:0] a_row, d_row;
    logic [IW-1:0] a_col, b_row;
    logic [OW-1:0] b_col, d_col;
    logic          a_last, b_last, d_last;
    logic          accept;

    assign accept = in_valid && in_ready;

    matmul_idx_counter #(.ROWS(N), .COLS(DIN)) u_cnt_a (
        .clk(clk), .reset(reset), .en(accept && (state == LOAD_A)),
        .row(a_row), .col(a_col), .last(a_last)
    );

    matmul_idx_counter #(.ROWS(DIN), .COLS(DOUT)) u_cnt_b (
        .clk(clk), .reset(reset), .en(accept && (state == LOAD_B)),
        .row(b_row), .col(b_col), .last(b_last)
    );

    matmul_idx_counter #(.ROWS(N), .COLS(DOUT)) u_cnt_d (
        .clk(clk), .reset(reset), .en(out_valid && out_ready && (state == DRAIN)),
        .row(d_row), .col(d_col), .last(d_last)
    );

    // Drain index only advances on a handshake, so data/last hold across stalls.
    assign out_data = res[d_row][d_col];
    assign out_last = out_valid && d_last;

`ifdef MATMUL_DRIVER_TIMEOUT_EN
    localparam int unsigned TCW = $clog2(TIMEOUT + 1);
    logic [TCW-1:0] tcnt;
    logic           tmo_q;
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD_A;
            START     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b0;
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < DIN; j++) a[i][j] <= '0;
            for (int unsigned i = 0; i < DIN; i++)
                for (int unsigned j = 0; j < DOUT; j++) b[i][j] <= '0;
            for (int unsigned i = 0; i < N; i++)
                for (int unsigned j = 0; j < DOUT; j++) res[i][j] <= '0;
`ifdef MATMUL_DRIVER_TIMEOUT_EN
            tcnt  <= '0;
            tmo_q <= 1'b0;
`endif
        end else begin
            case (state)
                LOAD_A: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        a[a_row][a_col] <= in_data[WIDTHA-1:0];
`ifdef MATMUL_DRIVER_TIMEOUT_EN
                        tmo_q <= 1'b0;
`endif
                        if (a_last) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (accept) begin
                        b[b_row][b_col] <= in_data[WIDTHB-1:0];
                        if (b_last) begin
                            state    <= RUN;
                            in_ready <= 1'b0;
                            START    <= 1'b1;
                            busy     <= 1'b1;
`ifdef MATMUL_DRIVER_TIMEOUT_EN
                            tcnt     <= '0;
`endif
                        end
                    end
                end
                RUN: begin
                    if (DONE) begin
                        res       <= c;
                        START     <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DRAIN;
                    end
`ifdef MATMUL_DRIVER_TIMEOUT_EN
                    else if (tcnt == TCW'(TIMEOUT - 1)) begin
                        START    <= 1'b0;
                        busy     <= 1'b0;
                        tmo_q    <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= LOAD_A;
                    end else begin
                        tcnt <= tcnt + TCW'(1);
                    end
`endif
                end
                DRAIN: begin
                    if (out_ready && d_last) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= LOAD_A;
                    end
                end
                default: state <= LOAD_A;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_driver.sv
// Directed bench for matmul_driver with a behavioural multiplier answering DONE 5 cycles after START.
module tb_matmul_driver;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [7:0] in_data = '0;
    logic START;
    logic DONE;
    logic done_m = 1'b0;
    logic done_x = 1'b0;
    logic signed [7:0]  a [3][3];
    logic signed [7:0]  b [3][3];
    logic signed [15:0] c [3][3];
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic out_last;
    logic busy;
    logic timeout_err;
    bit   mult_en = 1'b1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int d;
        bit l;
    } res_t;

    int   ld [18];
    res_t rv [9];

    always #5 clk = ~clk;

    assign DONE = done_m | done_x;

    matmul_driver #(.N(3), .DIN(3), .DOUT(3), .WIDTHA(8), .WIDTHB(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .START(START), .DONE(DONE), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    always_comb begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                c[i][j] = '0;
                for (int k = 0; k < 3; k++)
                    c[i][j] = c[i][j] + 16'(a[i][k]) * 16'(b[k][j]);
            end
    end

    initial begin : mult
        int  mcnt;
        bit  fired;
        mcnt  = 0;
        fired = 1'b0;
        forever begin
            @(negedge clk);
            if (done_m) done_m = 1'b0;
            else if (mult_en && START && !fired) begin
                mcnt++;
                if (mcnt == 5) begin
                    done_m = 1'b1;
                    fired  = 1'b1;
                end
            end else if (!START) begin
                mcnt  = 0;
                fired = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset();
        bit nz = 1'b0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (a[i][j] !== 8'sd0 || b[i][j] !== 8'sd0) nz = 1'b1;
        chk("rst_start", START, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_ab_zero", nz, 0);
        chk("rst_res_zero", out_data, 0);
    endtask

    task automatic load_all(input int gap, input bit pulse);
        int acc = 0;
        int guard = 0;
        bit early = 1'b0;
        while (acc < 18 && guard < 500) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b1;
            in_data  = 8'(ld[acc]);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc++;
                if (acc < 18 && START) early = 1'b1;
                if (acc < 18)
                    for (int g = 0; g < gap; g++) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                        done_x   = (pulse && acc == 10 && g == 0);
                        if (pulse && acc == 10 && g == 1) begin
                            chk("done_ignored_start", START, 0);
                            chk("done_ignored_ready", in_ready, 1);
                        end
                    end
            end
        end
        in_valid = 1'b0;
        done_x   = 1'b0;
        chk("accepts", acc, 18);
        chk("start_early", early, 0);
        chk("start_after_load", START, 1);
        chk("in_ready_run", in_ready, 0);
        chk("busy_run", busy, 1);
    endtask

    task automatic run_drain(input bit toggle);
        int guard = 0;
        int got = 0;
        bit stall = 1'b0;
        logic signed [15:0] hd = '0;
        logic hl = 1'b0;
        do begin
            @(negedge clk);
            #2;
            guard++;
        end while (!DONE && guard < 50);
        chk("done_seen", DONE, 1);
        chk("valid_before_done", out_valid, 0);
        @(posedge clk);
        #1;
        chk("valid_after_done", out_valid, 1);
        chk("start_after_done", START, 0);
        chk("first_data", out_data, rv[0].d);
        for (int cyc = 0; cyc < 100 && got < 9; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                if (stall) begin
                    chk("stall_data", out_data, hd);
                    chk("stall_last", out_last, hl);
                end
                out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
                if (out_ready) begin
                    chk("res_data", out_data, rv[got].d);
                    chk("res_last", out_last, rv[got].l);
                    got++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1;
                    hd = out_data;
                    hl = out_last;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("results", got, 9);
        chk("drain_end_valid", out_valid, 0);
        chk("drain_end_ready", in_ready, 1);
        chk("drain_end_busy", busy, 0);
    endtask

    initial begin
        ld = '{-1, 2, -3, 4, -5, 6, -7, 8, -9, -1, 2, -3, 4, -5, 6, -7, 8, -9};
        begin
            int exp_c [9] = '{30, -36, 42, -66, 81, -96, 102, -126, 150};
            for (int i = 0; i < 9; i++) begin
                rv[i].d = exp_c[i];
                rv[i].l = (i == 8);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("ready_first_edge", in_ready, 1);

        load_all(0, 1'b0);
        run_drain(1'b0);

        load_all(0, 1'b0);
        run_drain(1'b1);

        load_all(2, 1'b1);
        run_drain(1'b0);

        load_all(0, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset();
        @(negedge clk);
        reset = 1'b1;
        load_all(0, 1'b0);
        run_drain(1'b0);

`ifdef MATMUL_DRIVER_TIMEOUT_EN
        mult_en = 1'b0;
        load_all(0, 1'b0);
        begin
            int n = 0;
            bit sawv = 1'b0;
            while (START && n < 100) begin
                @(posedge clk);
                #1;
                n++;
                if (out_valid) sawv = 1'b1;
            end
            chk("tmo_run_cycles", n, 16);
            chk("tmo_out_valid", sawv, 0);
        end
        chk("tmo_err", timeout_err, 1);
        chk("tmo_in_ready", in_ready, 1);
        chk("tmo_busy", busy, 0);
        mult_en = 1'b1;
        load_all(0, 1'b0);
        chk("tmo_err_cleared", timeout_err, 0);
        run_drain(1'b0);
`else
        chk("timeout_err_tied", timeout_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
